// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard/control unit; sole driver of PC, IF_ID, ID_EX and EX_MEM stall/flush.
// Latency : stall/flush outputs are combinational (zero latency); counters and state update on clk.
// Backpressure: mem_busy freezes the whole pipe until it drops or the MAX_WAIT watchdog trips.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ID_inst, ID_regread1/2, ID_jump  decode-stage instruction and its source/jump flags
//   EX_inst, EX_memread, EX_redirect execute-stage instruction, load flag, taken branch/jr
//   mem_busy                        data memory not ready this cycle
//   pc_stall .. EX_MEM_stall        stall/flush controls for the pipeline registers
//   mem_timeout                     sticky watchdog flag
//   stall_cycles, flush_count       saturating performance counters
module hazard_ctrl #(
    parameter int LU_BUBBLES = 1,   // 1..3 bubbles per load-use hazard
    parameter int MAX_WAIT   = 64,  // >= 2 consecutive busy cycles before timeout
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ID_inst,
    input  logic             ID_regread1,
    input  logic             ID_regread2,
    input  logic             ID_jump,
    input  logic [31:0]      EX_inst,
    input  logic             EX_memread,
    input  logic             EX_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_stall,
    output logic             ID_EX_flush,
    output logic             EX_MEM_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [1:0]        LU_INIT   = 2'(LU_BUBBLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_LU,
        S_WAIT,
        S_TIMEOUT
    } state_t;

    state_t            state_q, state_d, eff;
    logic              ret_lu_q, ret_lu_d;     // WAIT returns to LU (1) or RUN (0)
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              tmo_q, tmo_d;

    logic lu_hit;
    logic busy_eff;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c, ex_mem_stall_c;

    // Only the register fields take part in hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{ID_inst[31:26], ID_inst[15:0], EX_inst[31:21], EX_inst[15:0]};

    assign lu_hit = EX_memread && (EX_inst[20:16] != 5'd0) &&
                    ((ID_regread1 && (ID_inst[25:21] == EX_inst[20:16])) ||
                     (ID_regread2 && (ID_inst[20:16] == EX_inst[20:16])));

    // Once the watchdog has fired, memory backpressure is no longer honoured.
    assign busy_eff = mem_busy && !tmo_q;

    always_comb begin
        state_d        = state_q;
        ret_lu_d       = ret_lu_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        tmo_d          = tmo_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;

        // When busy drops in WAIT the freeze releases in the same cycle, so the
        // returned-to state's rules are evaluated right away.
        eff = state_q;
        if (state_q == S_WAIT && !mem_busy) begin
            eff        = ret_lu_q ? S_LU : S_RUN;
            state_d    = eff;
            wait_cnt_d = '0;
        end

        case (eff)
            S_WAIT: begin
                pc_stall_c     = 1'b1;
                if_id_stall_c  = 1'b1;
                id_ex_stall_c  = 1'b1;
                ex_mem_stall_c = 1'b1;
                // wait_cnt counts earlier busy cycles; this one makes MAX_WAIT.
                if (wait_cnt_q == WAIT_LAST) begin
                    tmo_d      = 1'b1;
                    state_d    = S_TIMEOUT;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_LU: begin
                if (busy_eff) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    state_d        = S_WAIT;
                    ret_lu_d       = 1'b1;
                    wait_cnt_d     = WAIT_W'(1);
                end else begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (lu_cnt_q <= 2'd1) begin
                        lu_cnt_d = 2'd0;
                        state_d  = tmo_q ? S_TIMEOUT : S_RUN;
                    end else begin
                        lu_cnt_d = lu_cnt_q - 2'd1;
                    end
                end
            end
            default: begin  // S_RUN and S_TIMEOUT share the run-time rules
                if (busy_eff) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    state_d        = S_WAIT;
                    ret_lu_d       = 1'b0;
                    wait_cnt_d     = WAIT_W'(1);
                end else if (EX_redirect) begin
                    // ID holds a wrong-path instruction, so its hazard is moot.
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (lu_hit) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d  = S_LU;
                        lu_cnt_d = LU_INIT;
                    end
                end else if (ID_jump) begin
                    if_id_flush_c = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            ret_lu_q   <= 1'b0;
            lu_cnt_q   <= 2'd0;
            wait_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_lu_q   <= ret_lu_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // Combinational controls are forced low while reset is held.
    assign pc_stall     = rst_n && pc_stall_c;
    assign IF_ID_stall  = rst_n && if_id_stall_c;
    assign IF_ID_flush  = rst_n && if_id_flush_c;
    assign ID_EX_stall  = rst_n && id_ex_stall_c;
    assign ID_EX_flush  = rst_n && id_ex_flush_c;
    assign EX_MEM_stall = rst_n && ex_mem_stall_c;
    assign mem_timeout  = tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (IF_ID_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed scoreboard bench for hazard_ctrl (three parameterisations share stimulus).
// Latency : expected outputs are queued per cycle and compared half a cycle later.
// Backpressure: none; one vector is issued and one result checked every clock.
module tb_hazard_ctrl;

    localparam logic [31:0] LW8      = 32'h8C08_0000;  // lw $8
    localparam logic [31:0] LW0      = 32'h8C00_0000;  // lw $0
    localparam logic [31:0] ADD_RS8  = 32'h010A_4820;  // add $9,$8,$10
    localparam logic [31:0] ADD_RT8  = 32'h0148_0820;  // add $1,$10,$8
    localparam logic [31:0] ADD_ZERO = 32'h0000_4820;  // add $9,$0,$0

    // input bits {regread1, regread2, jump, memread, redirect, busy}
    localparam logic [5:0] I_RR1 = 6'b100000;
    localparam logic [5:0] I_RR2 = 6'b010000;
    localparam logic [5:0] I_JMP = 6'b001000;
    localparam logic [5:0] I_MRD = 6'b000100;
    localparam logic [5:0] I_RDR = 6'b000010;
    localparam logic [5:0] I_BSY = 6'b000001;

    // output bits {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] FRZ  = 6'b110101;
    localparam logic [5:0] LUS  = 6'b110010;
    localparam logic [5:0] RDR  = 6'b001010;
    localparam logic [5:0] JMP  = 6'b001000;

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] sel;
        logic [5:0] ctl;
        logic       tmo;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ID_inst, EX_inst;
    logic        ID_regread1, ID_regread2, ID_jump, EX_memread, EX_redirect, mem_busy;
    logic [14:0] act [1:3];

    exp_t sbq[$];
    exp_t m_e;
    logic [14:0] m_a, m_w;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance g has LU_BUBBLES=g; instance 3 gets a longer watchdog.
    for (genvar g = 1; g <= 3; g++) begin : g_dut
        logic ps, is, ifl, es, ef, ms, tmo;
        logic [3:0] sc, fc;
        hazard_ctrl #(
            .LU_BUBBLES(g),
            .MAX_WAIT  ((g == 3) ? 8 : 4),
            .CNT_W     (4)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .ID_inst     (ID_inst),
            .ID_regread1 (ID_regread1),
            .ID_regread2 (ID_regread2),
            .ID_jump     (ID_jump),
            .EX_inst     (EX_inst),
            .EX_memread  (EX_memread),
            .EX_redirect (EX_redirect),
            .mem_busy    (mem_busy),
            .pc_stall    (ps),
            .IF_ID_stall (is),
            .IF_ID_flush (ifl),
            .ID_EX_stall (es),
            .ID_EX_flush (ef),
            .EX_MEM_stall(ms),
            .mem_timeout (tmo),
            .stall_cycles(sc),
            .flush_count (fc)
        );
        assign act[g] = {ps, is, ifl, es, ef, ms, tmo, sc, fc};
    end

    // Monitor: pops one expectation per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            m_e = sbq.pop_front();
            m_a = act[m_e.sel];
            m_w = {m_e.ctl, m_e.tmo, m_e.sc, m_e.fc};
            n_tests++;
            if (m_a !== m_w) begin
                n_fail++;
                $display("FAIL chk%0d dut%0d: got ctl=%b tmo=%b sc=%0d fc=%0d, want ctl=%b tmo=%b sc=%0d fc=%0d",
                         m_e.tag, m_e.sel, m_a[14:9], m_a[8], m_a[7:4], m_a[3:0],
                         m_e.ctl, m_e.tmo, m_e.sc, m_e.fc);
            end
        end
    end

    task automatic cyc(input logic [7:0] tag, input logic rst, input logic [31:0] idi,
                       input logic [31:0] exi, input logic [5:0] inb, input logic [1:0] sel,
                       input logic [5:0] ectl, input logic etmo, input logic [3:0] esc,
                       input logic [3:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        ID_inst = idi;
        EX_inst = exi;
        {ID_regread1, ID_regread2, ID_jump, EX_memread, EX_redirect, mem_busy} = inb;
        e.tag = tag; e.sel = sel; e.ctl = ectl; e.tmo = etmo; e.sc = esc; e.fc = efc;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic [7:0] tag, input logic [1:0] sel, input logic [5:0] ectl,
                        input logic etmo, input logic [3:0] esc, input logic [3:0] efc);
        cyc(tag, 1'b1, 32'd0, 32'd0, 6'd0, sel, ectl, etmo, esc, efc);
    endtask

    task automatic rst_cyc(input logic [7:0] tag, input logic [1:0] sel);
        cyc(tag, 1'b0, 32'd0, 32'd0, 6'd0, sel, NONE, 1'b0, 4'd0, 4'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        ID_inst = '0; EX_inst = '0;
        {ID_regread1, ID_regread2, ID_jump, EX_memread, EX_redirect, mem_busy} = '0;
        #2 rst_n = 1'b0;

        // Reset: every control stays low even with all hazard inputs active.
        cyc(1, 1'b0, ADD_RS8, LW8, 6'b111111, 1, NONE, 0, 0, 0);
        cyc(2, 1'b0, ADD_RS8, LW8, 6'b111111, 2, NONE, 0, 0, 0);
        cyc(3, 1'b0, ADD_RS8, LW8, 6'b111111, 3, NONE, 0, 0, 0);

        // Load-use with one bubble; rs and rt matches, regread gating, non-load.
        rst_cyc(10, 1);
        cyc(11, 1, ADD_RS8, LW8, I_RR1 | I_MRD, 1, LUS, 0, 0, 0);
        idle(12, 1, NONE, 0, 1, 0);
        idle(13, 1, NONE, 0, 1, 0);
        cyc(14, 1, ADD_RT8, LW8, I_RR2 | I_MRD, 1, LUS, 0, 1, 0);
        cyc(15, 1, ADD_RT8, LW8, I_RR1 | I_MRD, 1, NONE, 0, 2, 0);
        cyc(16, 1, ADD_RS8, 32'd0, I_RR1, 1, NONE, 0, 2, 0);

        // $0 destination never stalls; two-bubble variant stalls exactly twice.
        rst_cyc(20, 2);
        cyc(21, 1, ADD_ZERO, LW0, I_RR1 | I_RR2 | I_MRD, 2, NONE, 0, 0, 0);
        cyc(22, 1, ADD_RS8, LW8, I_RR1 | I_MRD, 2, LUS, 0, 0, 0);
        idle(23, 2, LUS, 0, 1, 0);
        idle(24, 2, NONE, 0, 2, 0);

        // Redirect beats load-use; load-use beats jump; flush counting.
        rst_cyc(30, 1);
        cyc(31, 1, ADD_RS8, LW8, I_RR1 | I_MRD | I_RDR, 1, RDR, 0, 0, 0);
        idle(32, 1, NONE, 0, 0, 1);
        cyc(33, 1, 32'd0, 32'd0, I_JMP, 1, JMP, 0, 0, 1);
        idle(34, 1, NONE, 0, 0, 2);
        cyc(35, 1, ADD_RS8, LW8, I_RR1 | I_MRD | I_JMP, 1, LUS, 0, 0, 2);
        idle(36, 1, NONE, 0, 1, 2);

        // Memory wait entered from LU (3 bubbles): 5 freeze cycles, then 2 LU cycles.
        rst_cyc(40, 3);
        cyc(41, 1, ADD_RS8, LW8, I_RR1 | I_MRD, 3, LUS, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            cyc(8'(42 + k), 1, 32'd0, 32'd0, I_BSY, 3, FRZ, 0, 4'(k + 1), 0);
        idle(47, 3, LUS, 0, 6, 0);
        idle(48, 3, LUS, 0, 7, 0);
        idle(49, 3, NONE, 0, 8, 0);
        // Busy beats redirect; redirect applies the very cycle busy drops.
        cyc(50, 1, 32'd0, 32'd0, I_BSY | I_RDR, 3, FRZ, 0, 8, 0);
        cyc(51, 1, 32'd0, 32'd0, I_RDR, 3, RDR, 0, 9, 0);
        idle(52, 3, NONE, 0, 9, 1);

        // Watchdog with MAX_WAIT=4: 4 freeze cycles, then sticky timeout, busy ignored.
        rst_cyc(60, 1);
        for (int k = 0; k < 4; k++)
            cyc(8'(61 + k), 1, 32'd0, 32'd0, I_BSY, 1, FRZ, 0, 4'(k), 0);
        cyc(65, 1, 32'd0, 32'd0, I_BSY, 1, NONE, 1, 4, 0);
        cyc(66, 1, ADD_RS8, LW8, I_RR1 | I_MRD | I_BSY, 1, LUS, 1, 4, 0);
        cyc(67, 1, 32'd0, 32'd0, I_BSY, 1, NONE, 1, 5, 0);
        idle(68, 1, NONE, 1, 5, 0);
        rst_cyc(69, 1);

        // 20 stall cycles into a 4-bit counter: saturates at 15.
        rst_cyc(70, 1);
        for (int k = 0; k < 20; k++)
            cyc(8'(71 + k), 1, ADD_RS8, LW8, I_RR1 | I_MRD, 1, LUS, 0, (k < 15) ? 4'(k) : 4'd15, 0);
        idle(91, 1, NONE, 0, 15, 0);

        // Reset dropped mid-LU clears outputs and counters at once; restart in RUN.
        rst_cyc(92, 3);
        cyc(93, 1, ADD_RS8, LW8, I_RR1 | I_MRD, 3, LUS, 0, 0, 0);
        idle(94, 3, LUS, 0, 1, 0);
        cyc(95, 1'b0, ADD_RS8, LW8, I_RR1 | I_MRD, 3, NONE, 0, 0, 0);
        idle(96, 3, NONE, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, want end before 200000");
        $fatal(1, "watchdog");
    end

endmodule
